// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic-cycle slave in front of a word-organised RAM.
// Programmable wait states, byte-lane writes, ERR on out-of-range, abort on CYC drop.
module wb_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RangeBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CntInit    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, inr_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdat_q;
  logic [3:0]      sel_q;
  logic            ack_q, ack_d, err_q, err_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            req;
  logic [31:0]     off;
  logic            req_inr;
  logic [AW-1:0]   req_idx;
  logic            acc_we, acc_inr, ram_we;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_dat;
  logic [3:0]      acc_sel;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign off     = wbs_adr_i - BASE_ADDR;
  assign req_inr = (wbs_adr_i >= BASE_ADDR) && ({1'b0, off} < RangeBytes);
  assign req_idx = off[AW+1:2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      inr_q   <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= 32'd0;
      sel_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      if (state_q == StIdle && req) begin
        we_q   <= wbs_we_i;
        inr_q  <= req_inr;
        idx_q  <= req_idx;
        wdat_q <= wbs_dat_i;
        sel_q  <= wbs_sel_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (!wbs_cyc_i)         state_d = StIdle;
        else if (cnt_q == 4'd0) state_d = StResp;
        else                    cnt_d = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so use the live request.
  always_comb begin
    acc_we  = (state_q == StIdle) ? wbs_we_i  : we_q;
    acc_inr = (state_q == StIdle) ? req_inr   : inr_q;
    acc_idx = (state_q == StIdle) ? req_idx   : idx_q;
    acc_dat = (state_q == StIdle) ? wbs_dat_i : wdat_q;
    acc_sel = (state_q == StIdle) ? wbs_sel_i : sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    ram_we  = 1'b0;
    if (state_d == StResp && state_q != StResp) begin
      if (acc_inr) begin
        ack_d = 1'b1;
        if (acc_we) ram_we = ~rst_i;
        else        dat_d  = mem_q[acc_idx];
      end else begin
        err_d = 1'b1;
        dat_d = 32'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_sel[k]) mem_q[acc_idx][8*k +: 8] <= acc_dat[8*k +: 8];
      end
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone B4 classic-cycle responder that fronts a word-organised on-chip RAM. It sits on the memory side of the bus and answers the pipeline's Wishbone initiator. It samples a request, inserts a programmable number of wait states, then returns exactly one ACK or ERR per transfer. It supports byte-lane writes, rejects out-of-range addresses with ERR, and abandons the transfer cleanly if the initiator drops CYC.

## Interface
- DEPTH_WORDS, 1024 — RAM depth in 32-bit words; power of two, ≥ 2.
- WAIT_STATES, 1 — extra cycles between request sampling and ACK/ERR; range 0..15.
- BASE_ADDR, 32'h0000_0000 — byte address of word 0; aligned to DEPTH_WORDS*4.
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe; a transfer is requested when cyc&stb.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_adr_i  in  32  byte address; bits [1:0] ignored.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte-lane enables; bit k covers dat[8k+7:8k].
- wbs_dat_o  out  32  read data; valid only while wbs_ack_o=1 on a read.
- wbs_ack_o  out  1  normal termination, one-cycle pulse.
- wbs_err_o  out  1  error termination, one-cycle pulse.

## Operation
- Reset (async assert): state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, wait counter=0. RAM contents are not cleared.
- Decode: off = adr_i − BASE_ADDR, computed on 32 bits. The request is in range iff adr_i ≥ BASE_ADDR and off < DEPTH_WORDS*4. Word index = off[log2(DEPTH_WORDS)+1:2].
- States:
  - IDLE: when cyc&stb, latch we, word index, range flag, dat_i and sel_i. Go to RESP if WAIT_STATES==0; otherwise go to WAIT with cnt=WAIT_STATES−1.
  - WAIT: if !cyc_i, go to IDLE (abort). Else if cnt==0, go to RESP. Else decrement cnt.
  - RESP: ack_o or err_o high for exactly this cycle. Always go to IDLE next.
- Entry into RESP happens only if cyc_i=1 on that edge. Otherwise go to IDLE with no access.
- On the edge entering RESP:
  - In range, write: RAM[idx] bytes with sel=1 are updated from the latched data; bytes with sel=0 are unchanged. ack_o←1.
  - In range, read: dat_o←RAM[idx], full word regardless of sel. ack_o←1.
  - Out of range: err_o←1, dat_o←0, no RAM write.
- sel_i==4'b0000 on a write: ack, no bytes modified.
- On the edge leaving RESP: ack_o/err_o←0. dat_o holds its last value (don't-care outside ack).
- ack_o and err_o are never high together. Never more than one termination per sampled request.
- Inputs other than cyc_i are ignored while in WAIT or RESP; the latched values are used.
- cyc&stb still high in the first IDLE cycle after RESP starts a new transfer (back-to-back supported).

## Timing
- Cycle 0 = first cycle cyc&stb is seen in IDLE. ACK/ERR is high during cycle 1+WAIT_STATES.
- Throughput: one transfer per 2+WAIT_STATES cycles.
- Abort: if cyc_i drops in cycles 1..WAIT_STATES, no ack/err ever appears for that request and the RAM is unchanged. The block is in IDLE one cycle later.
- Reset mid-transfer: outputs go to 0 immediately (asynchronously). A pending write is not performed. Operation resumes in IDLE after rst_i deasserts.
- All outputs are registered; no combinational input→output path.

## Test plan
- Write then read, WAIT_STATES=1, BASE=0: write adr 0x10, dat 0xDEADBEEF, sel 0xF → ack high in cycle 2. Read adr 0x10 → ack in cycle 2, dat_o=0xDEADBEEF.
- Byte lanes: word 0x10=0xDEADBEEF; write dat 0x11223344 with sel 0b0101 → read returns 0xDE22BE44.
- Out of range, DEPTH_WORDS=1024: read adr 0x1000 → err pulse in cycle 1+WAIT_STATES, ack stays 0, dat_o=0. Write adr 0x1000 → err, and a read of 0x0 afterwards is unchanged.
- Abort, WAIT_STATES=3: write starts at cycle 0, cyc drops at cycle 2 → no ack/err in cycles 0..8, and a read of the target word shows the old data.
- Back-to-back, WAIT_STATES=0: cyc&stb held high for three reads of 0x0, 0x4, 0x8 → ack in cycles 1, 3, 5 with the matching data. ack is low in cycles 2 and 4.
- Async reset: assert rst_i mid-WAIT of a write → ack/err/dat_o drop to 0 before the next edge, no write occurs, and the first request after release completes normally.
